// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter and read sequencer in front of an 8-entry FIFO
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  rd_req,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_rd_en,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  rd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_err_q, rd_err_d;

    logic ereq0, ereq1;
    logic full_w, empty_w;
    logic wr_issue, rd_issue;

    // Occupancy flags come straight from the registered count
    assign full_w  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_w = (count_q == '0);

    // A producer already holding its grant this cycle is masked so a held request is not granted twice
    assign ereq0 = req0 && (state_q != GNT0);
    assign ereq1 = req1 && (state_q != GNT1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and write decision: round-robin on ties, stall while full
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        din_d   = din_q;
        if (ereq0 || ereq1) begin
            if (full_w) begin
                state_d = STALL;
            end else if (ereq0 && (!ereq1 || last_q)) begin
                state_d = GNT0;
                last_d  = 1'b0;
                din_d   = din0;
            end else begin
                state_d = GNT1;
                last_d  = 1'b1;
                din_d   = din1;
            end
        end
    end

    // Read decision and occupancy update, both using the count before this edge
    always_comb begin
        wr_issue = (state_d == GNT0) || (state_d == GNT1);
        rd_issue = rd_req && !empty_w;
        rd_en_d  = rd_issue;
        rd_err_d = rd_req && empty_w;
        count_d  = count_q;
        if (wr_issue && !rd_issue) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (rd_issue && !wr_issue) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    // Datapath registers: grant pointer, captured write data, count and read strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= 1'b1;
            din_q    <= '0;
            count_q  <= '0;
            rd_en_q  <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            din_q    <= din_d;
            count_q  <= count_d;
            rd_en_q  <= rd_en_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Output decode from state and registers
    always_comb begin
        gnt0       = (state_q == GNT0);
        gnt1       = (state_q == GNT1);
        fifo_wr_en = (state_q == GNT0) || (state_q == GNT1);
        fifo_din   = din_q;
        fifo_rd_en = rd_en_q;
        rd_err     = rd_err_q;
        count      = count_q;
        full       = full_w;
        empty      = empty_w;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard testbench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, rd_req;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1, fifo_wr_en, fifo_rd_en, full, empty, rd_err;
    logic [31:0] fifo_din;
    logic [3:0]  count;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_rd[$];
    int   checks   = 0;
    int   failures = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .din0       (din0),
        .req1       (req1),
        .din1       (din1),
        .rd_req     (rd_req),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_rd_en (fifo_rd_en),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .rd_err     (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents a strobe
    always @(negedge clk) begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        check("full_empty_exclusive", 32'(full & empty), 32'd0);
        if (fifo_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_gnt0", 32'(gnt0), 32'(e.id == 1'b0));
                check("wr_gnt1", 32'(gnt1), 32'(e.id == 1'b1));
                check("wr_data", fifo_din, e.data);
            end
        end
        if (fifo_rd_en || rd_err) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_read_event", 32'd1, 32'd0);
            end else begin
                logic k;
                k = exp_rd.pop_front();
                check("rd_en_kind", 32'(fifo_rd_en), 32'(!k));
                check("rd_err_kind", 32'(rd_err), 32'(k));
            end
        end
    end

    task automatic write0(input logic [31:0] d);
        bit got;
        wr_t e;
        got  = 0;
        req0 = 1'b1;
        din0 = d;
        e.id = 1'b0;
        e.data = d;
        exp_wr.push_back(e);
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        check("write0_granted", 32'(got), 32'd1);
        req0 = 1'b0;
    endtask

    initial begin
        wr_t e;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        din0 = '0; din1 = '0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_din", fifo_din, 32'd0);

        // Single write from producer 0
        reset = 1'b0; req0 = 1'b1; din0 = 32'hA5A5_A5A5;
        e.id = 1'b0; e.data = 32'hA5A5_A5A5; exp_wr.push_back(e);
        @(negedge clk);
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        check("t1_empty", 32'(empty), 32'd0);
        req0 = 1'b0;

        // Both producers from reset: alternate until full
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        din0 = 32'h0000_1000; din1 = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            e.id = 1'b0; e.data = 32'h0000_1000 + 32'(k); exp_wr.push_back(e);
            e.id = 1'b1; e.data = 32'h0000_2000 + 32'(k); exp_wr.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) din0 = din0 + 32'd1;
            else            din1 = din1 + 32'd1;
        end
        check("t2_count", 32'(count), 32'd8);
        check("t2_full", 32'(full), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_no_gnt", 32'(gnt0 | gnt1), 32'd0);
            check("t2_count_hold", 32'(count), 32'd8);
        end

        // Read from full while producer 1 waits
        req0 = 1'b0; rd_req = 1'b1;
        exp_rd.push_back(1'b0);
        e.id = 1'b1; e.data = 32'h0000_2004; exp_wr.push_back(e);
        @(negedge clk);
        rd_req = 1'b0;
        check("t3_rd_en", 32'(fifo_rd_en), 32'd1);
        check("t3_count7", 32'(count), 32'd7);
        check("t3_no_gnt1_yet", 32'(gnt1), 32'd0);
        @(negedge clk);
        check("t3_gnt1", 32'(gnt1), 32'd1);
        check("t3_count8", 32'(count), 32'd8);
        req1 = 1'b0;

        // Read while empty, then simultaneous write and read at count 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; rd_req = 1'b1;
        exp_rd.push_back(1'b1);
        @(negedge clk);
        rd_req = 1'b0;
        check("t4_rd_err", 32'(rd_err), 32'd1);
        check("t4_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t4_count0", 32'(count), 32'd0);
        @(negedge clk);
        check("t4_rd_err_pulse", 32'(rd_err), 32'd0);
        write0(32'h0000_3000);
        write0(32'h0000_3001);
        write0(32'h0000_3002);
        check("t4_count3", 32'(count), 32'd3);
        req1 = 1'b1; din1 = 32'h0000_4000; rd_req = 1'b1;
        e.id = 1'b1; e.data = 32'h0000_4000; exp_wr.push_back(e);
        exp_rd.push_back(1'b0);
        @(negedge clk);
        req1 = 1'b0; rd_req = 1'b0;
        check("t4_both_gnt1", 32'(gnt1), 32'd1);
        check("t4_both_rd_en", 32'(fifo_rd_en), 32'd1);
        check("t4_both_count", 32'(count), 32'd3);

        // Reset at count 5 with requests pending
        write0(32'h0000_3003);
        write0(32'h0000_3004);
        check("t5_count5", 32'(count), 32'd5);
        req0 = 1'b1; din0 = 32'h0000_5000;
        req1 = 1'b1; din1 = 32'h0000_6000;
        reset = 1'b1;
        @(negedge clk);
        check("t5_count0", 32'(count), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_no_gnt", 32'(gnt0 | gnt1), 32'd0);
        check("t5_no_wr", 32'(fifo_wr_en), 32'd0);
        check("t5_no_rd", 32'(fifo_rd_en), 32'd0);
        reset = 1'b0;
        e.id = 1'b0; e.data = 32'h0000_5000; exp_wr.push_back(e);
        @(negedge clk);
        check("t5_first_gnt0", 32'(gnt0), 32'd1);
        check("t5_count1", 32'(count), 32'd1);
        e.id = 1'b1; e.data = 32'h0000_6000; exp_wr.push_back(e);
        @(negedge clk);
        check("t5_then_gnt1", 32'(gnt1), 32'd1);
        req0 = 1'b0; req1 = 1'b0;

        repeat (2) @(negedge clk);
        check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
